switch_fifo_ctrl: RTL and testbench
===================================

Name: switch_fifo_ctrl

Overview:
- Parametrised synchronous FIFO for switch port buffering. It is the successor to the current per-port FIFO memory block.
- Adds the following over the current block:
  - full, empty and almost-full/almost-empty flags
  - occupancy count
  - overflow/underflow protection with sticky error flags
  - synchronous flush
  - registered read data qualified by a valid strobe
- Sits between the ingress parser and the egress arbiter; one instance per port.

Parameters:
- DATA_W, 8, word width in bits.
- DEPTH, 64, number of entries; must be a power of 2 and >= 4.
- AF_THRESH, DEPTH-4, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 4, almost_empty asserts when count <= AE_THRESH.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous clear of FIFO contents.
- wr_en  in  1  write request.
- data_in  in  DATA_W  write data.
- rd_en  in  1  read request.
- data_out  out  DATA_W  registered read data.
- rd_valid  out  1  data_out holds a newly read word this cycle.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.
- clr_err  in  1  clears overflow and underflow.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Pointers = 0, count = 0, data_out = 0, rd_valid = 0, overflow = 0, underflow = 0.
  - Hence empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - RAM contents are not reset.
  - rst overrides all other inputs.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide; the MSB is a wrap bit.
  - The RAM is addressed by the low bits, so wrap from DEPTH-1 to 0 is implicit.
- Write accept: wr_acc = wr_en & !full & !flush. On wr_acc, ram[wr_ptr] <= data_in and wr_ptr increments.
- Read accept: rd_acc = rd_en & !empty & !flush. On rd_acc, data_out <= ram[rd_ptr], rd_ptr increments, and rd_valid = 1 in the following cycle.
  - Read latency is 1 cycle.
  - Without rd_acc: rd_valid = 0 and data_out holds its last value; it is not zeroed.
- count update: count_next = count + wr_acc - rd_acc.
  - All flags are decoded from the registered count, so they update in the cycle after an access.
- Simultaneous read and write:
  - Not full and not empty: both accepted; count unchanged.
  - When full: read accepted, write rejected.
  - When empty: write accepted, read rejected. There is no bypass: the word is readable from the next cycle.
- Overflow: set when wr_en & full & !flush.
- Underflow: set when rd_en & empty & !flush.
- Errors are sticky until clr_err or rst. If clr_err and a new error event occur in the same cycle, set wins.
- Flush (flush=1 at a clock edge):
  - Pointers and count go to 0; rd_valid = 0 next cycle.
  - Concurrent wr_en/rd_en are ignored and not flagged as errors.
  - Sticky errors and data_out are preserved.
- Reset or flush mid-stream: any word in flight is discarded. The first word written afterwards is the first word read.
- No combinational path from any input to any output.

Decomposition:
- Package switch_fifo_pkg:
  - function for pointer width: $clog2(DEPTH)+1
  - localparams for default DATA_W, DEPTH and thresholds
  - constant ERR_NONE/ERR_OVF/ERR_UDF encoding, for future status-register export
- Sub-module switch_fifo_ram:
  - simple dual-port RAM, DEPTH x DATA_W
  - synchronous write; synchronous registered read (provides data_out)
  - no reset on the array
- switch_fifo_ctrl contains the pointers, count, flags and error logic, and instantiates switch_fifo_ram.

Test Plan:
- Reset/fill/drain, DEPTH=8:
  - Stimulus: rst, then write 0x01..0x08 on consecutive cycles, then read 8.
  - Required: full=1 and count=8 after the 8th write; almost_full=1 from count 4.
  - Required: reads return 0x01..0x08, each with rd_valid one cycle after rd_en; empty=1 at the end.
- Overflow/underflow:
  - Stimulus: write to a full FIFO.
  - Required: count stays 8, overflow=1, stored data unchanged.
  - Stimulus: read when empty.
  - Required: underflow=1, rd_valid=0.
  - Stimulus: clr_err together with a fresh overflow attempt.
  - Required: overflow stays 1.
  - Stimulus: clr_err alone.
  - Required: both flags clear.
- Simultaneous read and write:
  - Stimulus: at count=3, wr+rd for 20 cycles.
  - Required: count stays 3, data in order, pointers wrap past 7 with no corruption.
  - Stimulus: wr+rd at count=0.
  - Required: count -> 1, underflow=1.
  - Stimulus: wr+rd at count=8.
  - Required: count -> 7, overflow=1.
- Flush:
  - Stimulus: count=5, assert flush together with wr_en and rd_en.
  - Required next cycle: count=0, empty=1, rd_valid=0, no error flags set.
  - Stimulus: then write 0xAA and read.
  - Required: data_out=0xAA.
- Reset mid-operation:
  - Stimulus: count=6 with a read in flight, assert rst for 1 cycle.
  - Required: all outputs at reset values next cycle, including overflow/underflow=0.
- Parameter sweep:
  - Stimulus: DATA_W=32, DEPTH=4, AF_THRESH=3, AE_THRESH=1, random wr/rd for 1000 cycles checked against a reference queue model.
  - Required: count and flags match the model every cycle.

Source files
------------

// File: rtl/switch_fifo_pkg.sv
// Shared constants and helpers for the per-port switch FIFO.
// Defaults match the standard port-buffer configuration.
package switch_fifo_pkg;

   localparam int DEF_DATA_W    = 8;
   localparam int DEF_DEPTH     = 64;
   localparam int DEF_AF_THRESH = DEF_DEPTH - 4;
   localparam int DEF_AE_THRESH = 4;

   // Error codes reserved for a future status-register export.
   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_OVF  = 2'b01;
   localparam logic [1:0] ERR_UDF  = 2'b10;

   // Pointer/count width: address bits plus one wrap bit.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/switch_fifo_if.sv
// Port-side bundle of the switch FIFO.
// The master side is the parser/arbiter pair; the slave side is the FIFO.
interface switch_fifo_if
   import switch_fifo_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
);
   localparam int CW = ptr_w(DEPTH);

   // Handshake: a write is taken on any edge where wr_en=1, full=0 and
   // flush=0; a read is taken where rd_en=1, empty=0 and flush=0. The read
   // word appears on data_out one cycle later, marked by a single-cycle
   // rd_valid. Requests made while full/empty are dropped and latch the
   // sticky overflow/underflow flag.
   logic              flush;
   logic              wr_en;
   logic [DATA_W-1:0] data_in;
   logic              rd_en;
   logic              clr_err;
   logic [DATA_W-1:0] data_out;
   logic              rd_valid;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [CW-1:0]     count;
   logic              overflow;
   logic              underflow;

   modport master (
      output flush, wr_en, data_in, rd_en, clr_err,
      input  data_out, rd_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  flush, wr_en, data_in, rd_en, clr_err,
      output data_out, rd_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

endinterface

// File: rtl/switch_fifo_ram.sv
// Simple dual-port storage array with synchronous write and registered read.
// Only the read register is reset; the array itself is left uninitialised.
module switch_fifo_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 64,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // The read register keeps its value when no read is taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/switch_fifo_ctrl.sv
// Per-port switch FIFO: pointers, occupancy, flags and sticky error logic
// around a registered-read storage array.
module switch_fifo_ctrl
   import switch_fifo_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int AF_THRESH = DEPTH - 4,
   parameter int AE_THRESH = DEF_AE_THRESH
) (
   input  logic          clk,
   input  logic          rst,
   switch_fifo_if.slave  bus
);

   localparam int            PW      = ptr_w(DEPTH);
   localparam int            AW      = PW - 1;
   localparam logic [PW-1:0] ONE     = PW'(1);
   localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
   localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);
   localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);

   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     count_r;
   logic [PW-1:0]     count_next;
   logic              full_w;
   logic              empty_w;
   logic              wr_acc;
   logic              rd_acc;
   logic              ovf_set;
   logic              udf_set;
   logic              ovf_r;
   logic              udf_r;
   logic              rd_valid_r;
   logic [DATA_W-1:0] rdata;

   // Flags come from the registered count only, so no input reaches an output.
   assign full_w  = (count_r == DEPTH_C);
   assign empty_w = (count_r == '0);

   assign wr_acc  = bus.wr_en & ~full_w  & ~bus.flush;
   assign rd_acc  = bus.rd_en & ~empty_w & ~bus.flush;
   assign ovf_set = bus.wr_en &  full_w  & ~bus.flush;
   assign udf_set = bus.rd_en &  empty_w & ~bus.flush;

   always_comb begin
      count_next = count_r;
      case ({wr_acc, rd_acc})
         2'b10:   count_next = count_r + ONE;
         2'b01:   count_next = count_r - ONE;
         default: count_next = count_r;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_r    <= '0;
         rd_valid_r <= 1'b0;
         ovf_r      <= 1'b0;
         udf_r      <= 1'b0;
      end else begin
         if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
         end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ONE;
            if (rd_acc) rd_ptr <= rd_ptr + ONE;
            count_r <= count_next;
         end
         rd_valid_r <= rd_acc;
         // A fresh error event wins over a simultaneous clear.
         ovf_r <= ovf_set | (ovf_r & ~bus.clr_err);
         udf_r <= udf_set | (udf_r & ~bus.clr_err);
      end
   end

   switch_fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_acc),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (bus.data_in),
      .re    (rd_acc),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (rdata)
   );

   assign bus.data_out     = rdata;
   assign bus.rd_valid     = rd_valid_r;
   assign bus.full         = full_w;
   assign bus.empty        = empty_w;
   assign bus.almost_full  = (count_r >= AF_C);
   assign bus.almost_empty = (count_r <= AE_C);
   assign bus.count        = count_r;
   assign bus.overflow     = ovf_r;
   assign bus.underflow    = udf_r;

endmodule

// File: tb/tb_switch_fifo_ctrl.sv
// Directed bench for the switch FIFO (DEPTH=8) followed by a randomised
// sweep of a DATA_W=32, DEPTH=4 instance against a queue model.
module tb_switch_fifo_ctrl;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   logic [7:0]  exp_q [$];
   logic [31:0] exp_q4 [$];

   switch_fifo_if #(.DATA_W(8),  .DEPTH(8)) bus8 ();
   switch_fifo_if #(.DATA_W(32), .DEPTH(4)) bus4 ();

   switch_fifo_ctrl #(
      .DATA_W(8), .DEPTH(8), .AF_THRESH(4), .AE_THRESH(2)
   ) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8.slave)
   );

   switch_fifo_ctrl #(
      .DATA_W(32), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1)
   ) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4.slave)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver helpers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive8(input logic wr, input logic [7:0] din, input logic rd,
                         input logic fl, input logic ce);
      bus8.wr_en   = wr;
      bus8.data_in = din;
      bus8.rd_en   = rd;
      bus8.flush   = fl;
      bus8.clr_err = ce;
   endtask

   // scoreboard compare
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic flags8(input string tag, input int n);
      chk({tag, "_count"}, 64'(bus8.count),        64'(n));
      chk({tag, "_full"},  64'(bus8.full),         64'(n == 8));
      chk({tag, "_empty"}, 64'(bus8.empty),        64'(n == 0));
      chk({tag, "_af"},    64'(bus8.almost_full),  64'(n >= 4));
      chk({tag, "_ae"},    64'(bus8.almost_empty), 64'(n <= 2));
   endtask

   task automatic errs8(input string tag, input logic ovf, input logic udf);
      chk({tag, "_ovf"}, 64'(bus8.overflow),  64'(ovf));
      chk({tag, "_udf"}, 64'(bus8.underflow), 64'(udf));
   endtask

   task automatic read8(input string tag);
      chk({tag, "_rd_valid"}, 64'(bus8.rd_valid), 64'd1);
      chk({tag, "_data"},     64'(bus8.data_out), 64'(exp_q.pop_front()));
   endtask

   initial begin
      int          m_cnt;
      logic        m_ovf, m_udf, m_valid;
      logic [31:0] m_data;
      logic        wr, rd, fl, ce, wa, ra;
      logic [31:0] din;

      checks = 0;
      errors = 0;
      rst    = 1'b1;
      drive8(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      bus4.wr_en = 1'b0; bus4.data_in = '0; bus4.rd_en = 1'b0;
      bus4.flush = 1'b0; bus4.clr_err = 1'b0;

      // reset state
      tick();
      flags8("rst", 0);
      errs8("rst", 1'b0, 1'b0);
      chk("rst_rd_valid", 64'(bus8.rd_valid), 64'd0);
      chk("rst_data",     64'(bus8.data_out), 64'd0);
      rst = 1'b0;

      // fill with 0x01..0x08
      for (int i = 1; i <= 8; i++) begin
         drive8(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
         exp_q.push_back(8'(i));
         tick();
         flags8("fill", i);
      end

      // write while full is dropped and flagged
      drive8(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
      tick();
      flags8("ovf", 8);
      errs8("ovf", 1'b1, 1'b0);

      // drain: each word valid the cycle after its read request
      drive8(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         tick();
         read8("drain");
         flags8("drain", 8 - k);
      end

      // read while empty
      tick();
      chk("udf_rd_valid", 64'(bus8.rd_valid), 64'd0);
      chk("udf_data_hold", 64'(bus8.data_out), 64'h08);
      errs8("udf", 1'b1, 1'b1);

      // clear together with a fresh underflow: underflow stays set
      drive8(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      tick();
      errs8("clr_udf_race", 1'b0, 1'b1);

      drive8(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      tick();
      errs8("clr_alone", 1'b0, 1'b0);

      // simultaneous read/write at count 3, pointers wrap several times
      for (int i = 0; i < 3; i++) begin
         drive8(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
         exp_q.push_back(8'(8'h10 + i));
         tick();
      end
      flags8("pre_rw", 3);
      for (int i = 0; i < 20; i++) begin
         drive8(1'b1, 8'(8'h13 + i), 1'b1, 1'b0, 1'b0);
         exp_q.push_back(8'(8'h13 + i));
         tick();
         read8("rw3");
         flags8("rw3", 3);
      end
      drive8(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         read8("rw3_drain");
      end
      flags8("rw3_drain", 0);

      // read+write at empty: write only
      drive8(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
      exp_q.push_back(8'h55);
      tick();
      flags8("rw_empty", 1);
      errs8("rw_empty", 1'b0, 1'b1);
      chk("rw_empty_rd_valid", 64'(bus8.rd_valid), 64'd0);

      drive8(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      tick();
      errs8("clr2", 1'b0, 1'b0);

      for (int i = 0; i < 7; i++) begin
         drive8(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
         exp_q.push_back(8'(8'h60 + i));
         tick();
      end
      flags8("refill", 8);

      // read+write at full: read only
      drive8(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
      tick();
      flags8("rw_full", 7);
      errs8("rw_full", 1'b1, 1'b0);
      read8("rw_full");

      drive8(1'b1, 8'h78, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(8'h78);
      tick();
      flags8("top_up", 8);

      // clear together with a fresh overflow: overflow stays set
      drive8(1'b1, 8'h79, 1'b0, 1'b0, 1'b1);
      tick();
      flags8("clr_ovf_race", 8);
      errs8("clr_ovf_race", 1'b1, 1'b0);

      drive8(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      tick();
      errs8("clr3", 1'b0, 1'b0);

      drive8(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         read8("pre_flush");
      end
      flags8("pre_flush", 5);

      // flush with concurrent requests: ignored, not flagged, data_out held
      drive8(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
      tick();
      flags8("flush", 0);
      errs8("flush", 1'b0, 1'b0);
      chk("flush_rd_valid", 64'(bus8.rd_valid), 64'd0);
      chk("flush_data_hold", 64'(bus8.data_out), 64'h62);
      exp_q.delete();

      drive8(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(8'hAA);
      tick();
      flags8("post_flush_wr", 1);
      drive8(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      tick();
      read8("post_flush_rd");
      flags8("post_flush_rd", 0);

      // reset mid-stream with errors set and a read in flight
      tick();
      errs8("pre_rst_udf", 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         drive8(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
         tick();
      end
      flags8("pre_rst", 6);
      drive8(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      tick();
      chk("pre_rst_data", 64'(bus8.data_out), 64'h30);
      drive8(1'b1, 8'h44, 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      flags8("mid_rst", 0);
      errs8("mid_rst", 1'b0, 1'b0);
      chk("mid_rst_rd_valid", 64'(bus8.rd_valid), 64'd0);
      chk("mid_rst_data",     64'(bus8.data_out), 64'd0);
      exp_q.delete();

      drive8(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(8'hC3);
      tick();
      drive8(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      tick();
      read8("post_rst_rd");
      flags8("post_rst_rd", 0);
      drive8(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // randomised sweep of the DEPTH=4 instance against a queue model
      m_ovf = 1'b0; m_udf = 1'b0; m_valid = 1'b0; m_data = '0;
      for (int c = 0; c < 1000; c++) begin
         wr  = 1'($urandom_range(0, 1));
         rd  = 1'($urandom_range(0, 1));
         fl  = ($urandom_range(0, 39) == 0);
         ce  = ($urandom_range(0, 19) == 0);
         din = $urandom();
         bus4.wr_en = wr; bus4.rd_en = rd; bus4.flush = fl;
         bus4.clr_err = ce; bus4.data_in = din;

         m_cnt = exp_q4.size();
         wa = wr && (m_cnt != 4) && !fl;
         ra = rd && (m_cnt != 0) && !fl;
         m_ovf = (wr && (m_cnt == 4) && !fl) || (m_ovf && !ce);
         m_udf = (rd && (m_cnt == 0) && !fl) || (m_udf && !ce);
         m_valid = ra;
         if (ra) m_data = exp_q4.pop_front();
         if (wa) exp_q4.push_back(din);
         if (fl) exp_q4.delete();
         m_cnt = exp_q4.size();

         tick();
         chk("sw_count", 64'(bus4.count),        64'(m_cnt));
         chk("sw_full",  64'(bus4.full),         64'(m_cnt == 4));
         chk("sw_empty", 64'(bus4.empty),        64'(m_cnt == 0));
         chk("sw_af",    64'(bus4.almost_full),  64'(m_cnt >= 3));
         chk("sw_ae",    64'(bus4.almost_empty), 64'(m_cnt <= 1));
         chk("sw_ovf",   64'(bus4.overflow),     64'(m_ovf));
         chk("sw_udf",   64'(bus4.underflow),    64'(m_udf));
         chk("sw_valid", 64'(bus4.rd_valid),     64'(m_valid));
         chk("sw_data",  64'(bus4.data_out),     64'(m_data));
      end

      // report
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
